// File: rtl/i8088_inta_seq.sv
// Interrupt-acknowledge sequencer for an 8088-style core: issues the two INTA
// pulses to the PIC, captures the vector during the second, and hands it to the core.
module i8088_inta_seq #(
    parameter int INTA_W = 2,
    parameter int GAP_W  = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       intr_i,
    input  logic       ien_i,
    input  logic       boundary_i,
    output logic       inta_o,
    input  logic [7:0] data_i,
    output logic [7:0] vec_o,
    output logic       vec_valid_o,
    input  logic       vec_ready_i,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        INTA1,
        GAP,
        INTA2,
        DONE
    } state_t;

    localparam logic [3:0] INTA_LOAD = 4'(INTA_W - 1);
    localparam logic [3:0] GAP_LOAD  = 4'(GAP_W - 1);

    state_t     state;
    logic [3:0] cnt;

    // Outputs are registered alongside the state so each one reflects the
    // state being entered; the request inputs are ignored once INTA1 starts.
    // NOTE: all state and outputs use non-blocking assignments so every
    // register sees pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            inta_o      <= 1'b0;
            vec_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            vec_o       <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (intr_i && ien_i && boundary_i) begin
                        state  <= INTA1;
                        cnt    <= INTA_LOAD;
                        inta_o <= 1'b1;
                        busy_o <= 1'b1;
                    end
                end
                INTA1: begin
                    if (cnt == 4'd0) begin
                        state  <= GAP;
                        cnt    <= GAP_LOAD;
                        inta_o <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                GAP: begin
                    if (cnt == 4'd0) begin
                        state  <= INTA2;
                        cnt    <= INTA_LOAD;
                        inta_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                INTA2: begin
                    // The PIC drives the vector during the second pulse; latch it
                    // only as that pulse ends.
                    if (cnt == 4'd0) begin
                        state       <= DONE;
                        inta_o      <= 1'b0;
                        vec_valid_o <= 1'b1;
                        vec_o       <= data_i;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (vec_ready_i) begin
                        state       <= IDLE;
                        vec_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= 4'd0;
                    inta_o      <= 1'b0;
                    vec_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i8088_inta_seq.sv
// Scoreboard bench for i8088_inta_seq: default (2,1) and (1,3) instances share
// stimulus; a cycle-count reference model predicts each output every cycle.
module tb_i8088_inta_seq;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b1;
    logic       intr = 1'b0;
    logic       ien = 1'b0;
    logic       bnd = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready = 1'b0;

    logic       inta_d, valid_d, busy_d;
    logic [7:0] vec_d;
    logic       inta_a, valid_a, busy_a;
    logic [7:0] vec_a;

    logic       dut_inta[2];
    logic       dut_valid[2];
    logic       dut_busy[2];
    logic [7:0] dut_vec[2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    i8088_inta_seq u_def (
        .clk_i(clk), .rst_ni(rst_ni), .intr_i(intr), .ien_i(ien), .boundary_i(bnd),
        .inta_o(inta_d), .data_i(data), .vec_o(vec_d), .vec_valid_o(valid_d),
        .vec_ready_i(ready), .busy_o(busy_d)
    );

    i8088_inta_seq #(.INTA_W(1), .GAP_W(3)) u_alt (
        .clk_i(clk), .rst_ni(rst_ni), .intr_i(intr), .ien_i(ien), .boundary_i(bnd),
        .inta_o(inta_a), .data_i(data), .vec_o(vec_a), .vec_valid_o(valid_a),
        .vec_ready_i(ready), .busy_o(busy_a)
    );

    assign dut_inta[0] = inta_d;   assign dut_inta[1] = inta_a;
    assign dut_valid[0] = valid_d; assign dut_valid[1] = valid_a;
    assign dut_busy[0] = busy_d;   assign dut_busy[1] = busy_a;
    assign dut_vec[0] = vec_d;     assign dut_vec[1] = vec_a;

    function automatic int iw(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int gw(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_k counts cycles since the accepting edge (1 = first INTA cycle).
    bit       m_act[2] = '{1'b0, 1'b0};
    int       m_k[2]   = '{0, 0};
    bit [7:0] m_vec[2] = '{8'h00, 8'h00};
    bit [7:0] q0[$];
    bit [7:0] q1[$];

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 1'b0;
                m_k[i]   = 0;
                m_vec[i] = 8'h00;
            end
            q0.delete();
            q1.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                int last;
                last = 2 * iw(i) + gw(i);
                if (!m_act[i]) begin
                    if (intr && ien && bnd) begin
                        m_act[i] = 1'b1;
                        m_k[i]   = 1;
                    end
                end else if (m_k[i] > last) begin
                    if (ready) m_act[i] = 1'b0;
                end else begin
                    if (m_k[i] == last) begin
                        m_vec[i] = data;
                        if (i == 0) q0.push_back(data);
                        else        q1.push_back(data);
                    end
                    m_k[i]++;
                end
            end
        end
    end

    // Monitor: compares every output each cycle and pops the scoreboard on a handshake.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int  k, last;
            bit  e_inta, e_valid;
            bit [7:0] e_vec;
            k    = m_k[i];
            last = 2 * iw(i) + gw(i);
            e_inta  = m_act[i] && ((k >= 1 && k <= iw(i)) || (k >= iw(i) + gw(i) + 1 && k <= last));
            e_valid = m_act[i] && (k > last);
            check($sformatf("inta[%0d]", i), 32'(dut_inta[i]), 32'(e_inta));
            check($sformatf("valid[%0d]", i), 32'(dut_valid[i]), 32'(e_valid));
            check($sformatf("busy[%0d]", i), 32'(dut_busy[i]), 32'(m_act[i]));
            check($sformatf("vec_hold[%0d]", i), 32'(dut_vec[i]), 32'(m_vec[i]));
            if (dut_valid[i] && ready) begin
                if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                    check($sformatf("sb_empty[%0d]", i), 32'(dut_valid[i]), 32'(0));
                end else begin
                    e_vec = (i == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("sb_vec[%0d]", i), 32'(dut_vec[i]), 32'(e_vec));
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic request_one_edge();
        intr = 1'b1; ien = 1'b1; bnd = 1'b1;
        tick();
        intr = 1'b0; ien = 1'b0; bnd = 1'b0;
    endtask

    initial begin
        #2 rst_ni = 1'b0;
        #1;
        check("rst_inta", 32'(inta_d), 32'(0));
        check("rst_valid", 32'(valid_d), 32'(0));
        check("rst_busy", 32'(busy_d), 32'(0));
        check("rst_vec", 32'(vec_d), 32'(8'h00));
        tick(2);
        rst_ni = 1'b1;
        tick(2);

        // Basic sequence with the core always ready.
        data = 8'h0A; ready = 1'b1;
        request_one_edge();
        tick(9);

        // Request blocked by ien or boundary for 20 cycles.
        intr = 1'b1; ien = 1'b0; bnd = 1'b1;
        tick(10);
        ien = 1'b1; bnd = 1'b0;
        tick(10);
        intr = 1'b0; ien = 1'b0;
        tick(2);

        // Request dropped during the gap.
        data = 8'h5C;
        intr = 1'b1; ien = 1'b1; bnd = 1'b1;
        tick();
        tick(2);
        intr = 1'b0; ien = 1'b0; bnd = 1'b0;
        tick(8);

        // Core stalls in DONE while the bus changes.
        data = 8'h0A; ready = 1'b0;
        request_one_edge();
        tick(5);
        data = 8'hFF;
        tick(5);
        ready = 1'b1;
        tick(4);

        // Reset in the middle of the second pulse.
        data = 8'h33;
        request_one_edge();
        tick(3);
        #2 rst_ni = 1'b0;
        #1;
        check("midrst_inta", 32'(inta_d), 32'(0));
        check("midrst_busy", 32'(busy_d), 32'(0));
        check("midrst_valid", 32'(valid_d), 32'(0));
        check("midrst_busy_alt", 32'(busy_a), 32'(0));
        tick();
        rst_ni = 1'b1;
        tick(10);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            intr  = ($urandom_range(0, 3) != 0);
            ien   = ($urandom_range(0, 3) != 0);
            bnd   = ($urandom_range(0, 1) != 0);
            ready = ($urandom_range(0, 2) != 0);
            data  = 8'($urandom);
            tick();
        end

        intr = 1'b0; ien = 1'b0; bnd = 1'b0; ready = 1'b1;
        tick(20);
        check("sb_drained0", 32'(q0.size()), 32'(0));
        check("sb_drained1", 32'(q1.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
